// File: rtl/bram_pattern_checker_pkg.sv
// Shared definitions for the BRAM pattern checker: FSM state codes, pattern
// mode codes and the pattern generator used for both writing and checking.
package bram_check_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0] PAT_SHL1   = 2'd0;
  localparam logic [1:0] PAT_INV    = 2'd1;
  localparam logic [1:0] PAT_WALK1  = 2'd2;
  localparam logic [1:0] PAT_XOR_A5 = 2'd3;

  // Widest word the generator supports; callers truncate to their DATA_W.
  localparam int PAT_MAX_W = 256;

  // Pattern word for address a at word width w (result truncated by caller).
  function automatic logic [PAT_MAX_W-1:0] p(input logic [1:0] mode,
                                              input logic [31:0] a,
                                              input int unsigned w);
    logic [PAT_MAX_W-1:0] a_ext;
    logic [PAT_MAX_W-1:0] r;
    a_ext = {{(PAT_MAX_W-32){1'b0}}, a};
    r = '0;
    case (mode)
      PAT_SHL1:  r = a_ext << 1;
      PAT_INV:   r = ~a_ext;
      PAT_WALK1: r[8'(a % w)] = 1'b1;
      default:   r = a_ext ^ {(PAT_MAX_W/8){8'hA5}};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bram_pattern_checker_if.sv
// Control and status bundle of the BRAM pattern checker. The master side
// (board logic or bench) drives the requests; the slave side reports status.
interface bram_pattern_checker_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              enable;
  logic              start;
  logic [1:0]        mode;
  logic              loop_en;
  logic              inject_err;
  logic              busy;
  logic              done;
  logic              pass;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [15:0]       loop_count;
  logic [DATA_W-1:0] read_data_out;

  modport master (
    output enable, start, mode, loop_en, inject_err,
    input  busy, done, pass, err_count, first_err_addr, loop_count, read_data_out
  );

  modport slave (
    input  enable, start, mode, loop_en, inject_err,
    output busy, done, pass, err_count, first_err_addr, loop_count, read_data_out
  );
endinterface

// File: rtl/bram_pattern_checker_simple_dp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// output, single clock. Written to map onto block RAM.
module simple_dp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk_100mhz,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // write port
  always_ff @(posedge clk_100mhz) begin
    if (we) mem[waddr] <= wdata;
  end

  // read port, one cycle latency
  always_ff @(posedge clk_100mhz) begin
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/bram_pattern_checker.sv
// BRAM self-test engine: waits a settle delay, fills the RAM with a pattern,
// reads it back and counts mismatches. Optional error injection and looping.
module bram_pattern_checker
  import bram_check_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int START_DELAY = 50
) (
  input logic                  clk_100mhz,
  input logic                  reset,
  bram_pattern_checker_if.slave bus
);
  localparam int DLY_W    = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int DLY_LAST = (START_DELAY > 0) ? START_DELAY - 1 : 0;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [DLY_W-1:0]  dly_cnt;
  logic              drain_cnt;
  logic [1:0]        mode_q;
  logic              loop_q;
  logic              inj_q;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic              first_seen;
  logic [15:0]       loop_count;

  logic              start_take;
  logic              we;
  logic              re;
  logic [DATA_W-1:0] pat;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  logic              vld_p0;
  logic              rd_seen;
  logic [DATA_W-1:0] exp_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic              mis_p1;
  logic [ADDR_W-1:0] addr_p1;

  assign start_take = ((state == S_IDLE) || (state == S_DONE)) && bus.start && bus.enable;
  assign we         = (state == S_WRITE) && bus.enable;
  assign re         = (state == S_READ) && bus.enable;
  assign pat        = DATA_W'(p(mode_q, 32'(addr), DATA_W));
  // Injected fault: bit 0 of the last word is flipped on every write pass.
  assign wdata      = pat ^ {{(DATA_W-1){1'b0}}, inj_q & (&addr)};

  simple_dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk_100mhz (clk_100mhz),
    .we         (we),
    .waddr      (addr),
    .wdata      (wdata),
    .re         (re),
    .raddr      (addr),
    .rdata      (rdata)
  );

  // Sequencer: settle delay, write sweep, read sweep, pipeline drain.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state      <= S_IDLE;
      addr       <= '0;
      dly_cnt    <= '0;
      drain_cnt  <= 1'b0;
      mode_q     <= 2'd0;
      loop_q     <= 1'b0;
      inj_q      <= 1'b0;
      loop_count <= 16'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_take) begin
            state      <= (START_DELAY == 0) ? S_WRITE : S_WAIT;
            addr       <= '0;
            dly_cnt    <= '0;
            mode_q     <= bus.mode;
            loop_q     <= bus.loop_en;
            inj_q      <= bus.inject_err;
            loop_count <= 16'd0;
          end
        end
        S_WAIT: begin
          if (!bus.enable) state <= S_IDLE;
          else if (dly_cnt == DLY_W'(DLY_LAST)) state <= S_WRITE;
          else dly_cnt <= dly_cnt + 1'b1;
        end
        S_WRITE: begin
          if (!bus.enable) state <= S_IDLE;
          else begin
            addr <= addr + 1'b1;
            if (&addr) state <= S_READ;
          end
        end
        S_READ: begin
          if (!bus.enable) state <= S_IDLE;
          else begin
            addr <= addr + 1'b1;
            if (&addr) begin
              state     <= S_DRAIN;
              drain_cnt <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (!bus.enable) state <= S_IDLE;
          else if (drain_cnt) begin
            if (loop_q) begin
              state      <= S_WRITE;
              loop_count <= loop_count + 16'd1;
            end else begin
              state <= S_DONE;
            end
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p0: RAM word arrives; expected word and address travel alongside.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      rd_seen <= 1'b0;
    end else begin
      vld_p0 <= re;
      if (re) rd_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    exp_p0  <= pat;
    addr_p0 <= addr;
  end

  // Stage p1: registered compare result.
  always_ff @(posedge clk_100mhz) begin
    if (reset) mis_p1 <= 1'b0;
    else       mis_p1 <= vld_p0 && (rdata != exp_p0);
  end

  always_ff @(posedge clk_100mhz) begin
    addr_p1 <= addr_p0;
  end

  // Status: counts are cleared by a new run and frozen once the run is aborted.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      err_count      <= 16'd0;
      first_err_addr <= '0;
      first_seen     <= 1'b0;
    end else if (start_take) begin
      err_count      <= 16'd0;
      first_err_addr <= '0;
      first_seen     <= 1'b0;
    end else if (mis_p1 && bus.enable && ((state == S_READ) || (state == S_DRAIN))) begin
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      if (!first_seen) begin
        first_seen     <= 1'b1;
        first_err_addr <= addr_p1;
      end
    end
  end

  assign bus.busy           = (state == S_WAIT) || (state == S_WRITE) ||
                              (state == S_READ) || (state == S_DRAIN);
  assign bus.done           = (state == S_DONE);
  assign bus.pass           = (state == S_DONE) && (err_count == 16'd0);
  assign bus.err_count      = err_count;
  assign bus.first_err_addr = first_err_addr;
  assign bus.loop_count     = loop_count;
  assign bus.read_data_out  = rd_seen ? rdata : '0;
endmodule
